// File: rtl/tpu_wb_initiator.sv
// Wishbone classic single-transfer initiator for the TPU slave window: n_writes from the write FIFO, then n_reads into the read FIFO.
// Optional stb-to-ack watchdog enabled by defining TPU_WB_TIMEOUT_EN.

module tpu_wb_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= push_data;
    end

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    // Head reads as zero when empty so the host never sees stale storage.
    assign head  = empty ? '0 : mem[rp[AW-1:0]];
endmodule

module tpu_wb_initiator #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          TIMEOUT      = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    input  logic        start,
    input  logic [3:0]  n_writes,
    input  logic [3:0]  n_reads,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [31:0] rd_data,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, FIN} state_t;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_req_t;

    localparam wb_req_t BUS_IDLE = '0;

    function automatic wb_req_t beat(input logic we, input logic [31:0] dat);
        wb_req_t b;
        b.cyc = 1'b1;
        b.stb = 1'b1;
        b.we  = we;
        b.sel = 4'hF;
        b.adr = BASE_ADDRESS;
        b.dat = we ? dat : 32'h0;
        return b;
    endfunction

    state_t      state;
    wb_req_t     bus;
    logic [3:0]  wcnt, rcnt;
    logic        wr_full, wr_empty, rd_full, rd_empty;
    logic [31:0] wr_head;
    logic        ack_ok, wr_push, wr_pop, rd_push, rd_pop, timeout_hit;

    // Acks are only meaningful against our own strobe.
    assign ack_ok  = bus.stb & wb_ack_i;
    assign wr_push = wr_valid & ~wr_full;
    assign wr_pop  = (state == WR_REQ) & ack_ok;
    assign rd_push = (state == RD_REQ) & ack_ok;
    assign rd_pop  = rd_ready & ~rd_empty;

    tpu_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_wr_fifo (
        .clk(clk), .rst(rst), .flush(timeout_hit),
        .push(wr_push), .push_data(wr_data), .pop(wr_pop),
        .head(wr_head), .full(wr_full), .empty(wr_empty)
    );

    tpu_wb_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_rd_fifo (
        .clk(clk), .rst(rst), .flush(1'b0),
        .push(rd_push), .push_data(wb_dat_i), .pop(rd_pop),
        .head(rd_data), .full(rd_full), .empty(rd_empty)
    );

`ifdef TPU_WB_TIMEOUT_EN
    logic [3:0] wdog;

    always_ff @(posedge clk) begin
        if (rst || !bus.stb || wb_ack_i) wdog <= '0;
        else                             wdog <= wdog + 4'd1;
    end

    // Fires at the end of the TIMEOUT-th strobe cycle without an ack.
    assign timeout_hit = bus.stb & ~wb_ack_i & (wdog == 4'(TIMEOUT - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus   <= BUS_IDLE;
            wcnt  <= '0;
            rcnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done <= 1'b0;
            if (timeout_hit) begin
                bus   <= BUS_IDLE;
                error <= 1'b1;
                state <= FIN;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        wcnt  <= n_writes;
                        rcnt  <= n_reads;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        if (n_writes != 4'd0)     state <= WR_REQ;
                        else if (n_reads != 4'd0) state <= RD_REQ;
                        else                      state <= FIN;
                    end
                    WR_REQ: begin
                        if (!bus.stb) begin
                            if (!wr_empty) bus <= beat(1'b1, wr_head);
                        end else if (wb_ack_i) begin
                            bus   <= BUS_IDLE;
                            wcnt  <= wcnt - 4'd1;
                            state <= WR_GAP;
                        end
                    end
                    // Gap states re-raise stb directly so the next strobe lands two cycles after the ack.
                    WR_GAP: begin
                        if (wcnt != 4'd0) begin
                            state <= WR_REQ;
                            if (!wr_empty) bus <= beat(1'b1, wr_head);
                        end else if (rcnt != 4'd0) begin
                            state <= RD_REQ;
                            if (!rd_full) bus <= beat(1'b0, 32'h0);
                        end else begin
                            state <= FIN;
                        end
                    end
                    RD_REQ: begin
                        if (!bus.stb) begin
                            if (!rd_full) bus <= beat(1'b0, 32'h0);
                        end else if (wb_ack_i) begin
                            bus   <= BUS_IDLE;
                            rcnt  <= rcnt - 4'd1;
                            state <= RD_GAP;
                        end
                    end
                    RD_GAP: begin
                        if (rcnt != 4'd0) begin
                            state <= RD_REQ;
                            if (!rd_full) bus <= beat(1'b0, 32'h0);
                        end else begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign wr_ready = ~wr_full;
    assign rd_valid = ~rd_empty;
    assign wb_cyc_o = bus.cyc;
    assign wb_stb_o = bus.stb;
    assign wb_we_o  = bus.we;
    assign wb_sel_o = bus.sel;
    assign wb_adr_o = bus.adr;
    assign wb_dat_o = bus.dat;
endmodule
